imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Arbitrates the single instruction-memory port between the fetch stage and a program loader (boot/debug write path). In RUN it passes the fetch PC to the memory and generates PCWrite. On a loader request it quiesces fetch, grants the port, counts loaded words, then restarts fetch from address 0 with a one-cycle PC reset pulse. It sits between the fetch stage, the hazard unit, the instruction memory and the loader.

## Interface
- PC_WIDTH, 6, byte-address width of the PC
- CODE_DIR_WIDTH, 4, word-index width of the instruction memory
- CODE_DEPTH, 16, number of instruction words
- LD_TIMEOUT, 255, max idle cycles in LOAD before abort (8-bit counter)
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  PC_WIDTH  fetch PC (byte address)
- hz_stall  in  1  hazard-unit stall request
- PCWrite  out  1  PC register enable to fetch
- if_valid  out  1  fetched instruction is valid; 0 = bubble
- if_instr  out  32  instruction to IF/ID; 32'h0 (NOP) when if_valid=0
- exc_misalign  out  1  fetch PC not word-aligned (RUN only)
- pc_restart  out  1  one-cycle pulse forcing PC to 0
- ld_req  in  1  loader requests the port (level, held for whole burst)
- ld_we  in  1  loader write strobe
- ld_addr  in  CODE_DIR_WIDTH  loader word index
- ld_data  in  32  loader write data
- ld_gnt  out  1  loader owns the port
- ld_count  out  CODE_DIR_WIDTH+1  words written in current/last burst
- ld_err  out  1  sticky: last burst aborted by timeout
- mem_addr  out  CODE_DIR_WIDTH  memory word index
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

## Operation
- States: RUN, QUIESCE, LOAD, RESUME. Reset → RUN.
- RUN: mem_addr = if_pc[CODE_DIR_WIDTH+1:2]; mem_we=0; if_valid=1; if_instr=mem_rdata; PCWrite = ~hz_stall; exc_misalign = (if_pc[1:0]!=0). ld_req=1 → QUIESCE.
- QUIESCE (1 cycle): PCWrite=0, if_valid=0, if_instr=0; clears ld_count, ld_err, idle counter → LOAD.
- LOAD: ld_gnt=1; mem_addr=ld_addr, mem_we=ld_we, mem_wdata=ld_data; PCWrite=0, if_valid=0. Each cycle with ld_we=1: ld_count += 1, saturating at CODE_DEPTH; idle counter cleared. ld_we=0: idle counter += 1. ld_req=0 → RESUME. Idle counter reaching LD_TIMEOUT → ld_err=1, → RESUME (write in that cycle is still performed if ld_we=1 — it clears the counter, so timeout and write never coincide).
- RESUME (1 cycle): pc_restart=1, PCWrite=0, if_valid=0 → RUN.
- ld_gnt is 0 in all states but LOAD; loader writes outside LOAD are ignored (mem_we=0).
- mem_wdata = ld_data in all states (don't-care when mem_we=0).
- hz_stall ignored outside RUN. ld_req deassert during QUIESCE: still enters LOAD, leaves next cycle via RESUME.
- If ld_req is still high at return to RUN, a new burst starts: RUN for one cycle, then QUIESCE.

## Timing
- Reset values: state RUN, ld_gnt 0, ld_count 0, ld_err 0, idle counter 0, pc_restart 0. While rst=1: PCWrite=0, if_valid=0, mem_we=0 (forced combinationally).
- State, ld_count, ld_err, idle counter registered; ld_gnt, pc_restart, PCWrite, if_valid, mem_* decoded combinationally from registered state.
- ld_req high at edge N (in RUN) → QUIESCE at N+1, ld_gnt=1 from N+2.
- ld_req low sampled in LOAD at edge M → pc_restart during cycle M+1, fetch of address 0 valid from M+2.
- Minimum loader turnaround RUN→RUN: 3 cycles plus LOAD length.

## Structure
- Shared package: state encoding (2-bit, RUN=0, QUIESCE=1, LOAD=2, RESUME=3), NOP constant 32'h0.
- No sub-module needed; idle counter and word counter live inline.

## Test plan
- Reset then RUN with if_pc=0,4,8, hz_stall=0 → mem_addr 0,1,2; PCWrite=1; if_instr=mem_rdata; exc_misalign=0.
- hz_stall=1 for 2 cycles in RUN → PCWrite=0 those cycles, if_valid stays 1.
- if_pc=6 → exc_misalign=1, mem_addr=1.
- ld_req at edge 10, 3 writes (addr 0..2, data A,B,C), ld_req drop → ld_gnt from edge 12, ld_count=3, pc_restart one cycle, then fetch addr 0 returns A.
- 20 writes in one burst (CODE_DEPTH=16) → ld_count saturates at 16.
- LOAD with no writes for 255 cycles → ld_err=1, RESUME, RUN; ld_err cleared on next QUIESCE; rst asserted mid-LOAD → RUN, ld_gnt=0 next cycle.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RESUME  = 2'd3
  } arb_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and memory-port signals around the arbiter.
// slave: the arbiter's view; master: the surrounding pipeline/loader/memory.
interface imem_port_arbiter_if #(
  parameter int PC_WIDTH       = 6,
  parameter int CODE_DIR_WIDTH = 4
);

  // fetch / hazard side
  logic [PC_WIDTH-1:0]       if_pc;
  logic                      hz_stall;
  logic                      PCWrite;
  logic                      if_valid;
  logic [31:0]               if_instr;
  logic                      exc_misalign;
  logic                      pc_restart;

  // loader side
  logic                      ld_req;
  logic                      ld_we;
  logic [CODE_DIR_WIDTH-1:0] ld_addr;
  logic [31:0]               ld_data;
  logic                      ld_gnt;
  logic [CODE_DIR_WIDTH:0]   ld_count;
  logic                      ld_err;

  // instruction memory side
  logic [CODE_DIR_WIDTH-1:0] mem_addr;
  logic                      mem_we;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;

  modport slave (
    input  if_pc, hz_stall, ld_req, ld_we, ld_addr, ld_data, mem_rdata,
    output PCWrite, if_valid, if_instr, exc_misalign, pc_restart,
           ld_gnt, ld_count, ld_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_pc, hz_stall, ld_req, ld_we, ld_addr, ld_data, mem_rdata,
    input  PCWrite, if_valid, if_instr, exc_misalign, pc_restart,
           ld_gnt, ld_count, ld_err, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory port between fetch and the program loader.
// RUN serves fetch; a loader request drains fetch (QUIESCE), hands the port
// over (LOAD) and finally restarts fetch from address 0 (RESUME).
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int PC_WIDTH       = 6,
  parameter int CODE_DIR_WIDTH = 4,
  parameter int CODE_DEPTH     = 16,
  parameter int LD_TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst,
  imem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = CODE_DIR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(CODE_DEPTH);
  localparam logic [7:0]       TIMEOUT = 8'(LD_TIMEOUT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] ld_count_q, ld_count_d;
  logic             ld_err_q, ld_err_d;
  logic [7:0]       idle_q, idle_d;

  logic [PC_WIDTH-1:0] pc;
  logic                st_run, st_load;

  assign pc      = bus.if_pc;
  assign st_run  = (state_q == ST_RUN);
  assign st_load = (state_q == ST_LOAD);

  // Next-state, burst word counter, idle counter and timeout flag.
  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    idle_d     = idle_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.ld_req) state_d = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        ld_count_d = '0;
        ld_err_d   = 1'b0;
        idle_d     = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.ld_we) begin
          idle_d = '0;
          if (ld_count_q < DEPTH) ld_count_d = ld_count_q + 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        // A write clears the idle count, so a timeout only fires on an idle cycle.
        if (!bus.ld_we && idle_d == TIMEOUT) begin
          ld_err_d = 1'b1;
          state_d  = ST_RESUME;
        end else if (!bus.ld_req) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
      idle_q     <= idle_d;
    end
  end

  // Port outputs decoded from the registered state; reset masks fetch and writes.
  assign bus.PCWrite      = st_run & ~bus.hz_stall & ~rst;
  assign bus.if_valid     = st_run & ~rst;
  assign bus.if_instr     = bus.if_valid ? bus.mem_rdata : NOP_INSTR;
  assign bus.exc_misalign = st_run & (pc[1:0] != 2'b00);
  assign bus.pc_restart   = (state_q == ST_RESUME);
  assign bus.ld_gnt       = st_load;
  assign bus.ld_count     = ld_count_q;
  assign bus.ld_err       = ld_err_q;
  assign bus.mem_addr     = st_load ? bus.ld_addr : pc[CODE_DIR_WIDTH+1:2];
  assign bus.mem_we       = st_load & bus.ld_we & ~rst;
  assign bus.mem_wdata    = bus.ld_data;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed and random fetch/load
// traffic compared every cycle against a behavioural model of the port.
module tb_imem_port_arbiter;

  logic clk;
  logic rst;

  imem_port_arbiter_if #(.PC_WIDTH(6), .CODE_DIR_WIDTH(4)) bus ();

  imem_port_arbiter #(
    .PC_WIDTH(6),
    .CODE_DIR_WIDTH(4),
    .CODE_DEPTH(16),
    .LD_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // instruction memory contents seen by the DUT, and the model's expectation
  logic [31:0] tb_mem  [16];
  logic [31:0] ref_mem [16];

  assign bus.mem_rdata = tb_mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // behavioural model
  string       m_mode;
  int unsigned m_count;
  bit          m_err;
  int unsigned m_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = "RUN";
    m_count = 0;
    m_err   = 1'b0;
    m_idle  = 0;
  endtask

  // Advance the model by one rising edge using the inputs held during the cycle.
  task automatic model_update();
    bit timeout;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == "RUN") begin
      if (bus.ld_req) m_mode = "QUIESCE";
    end else if (m_mode == "QUIESCE") begin
      m_count = 0;
      m_err   = 1'b0;
      m_idle  = 0;
      m_mode  = "LOAD";
    end else if (m_mode == "LOAD") begin
      timeout = 1'b0;
      if (bus.ld_we) begin
        ref_mem[bus.ld_addr] = bus.ld_data;
        m_count = (m_count + 1 > 16) ? 16 : m_count + 1;
        m_idle  = 0;
      end else begin
        m_idle = m_idle + 1;
        timeout = (m_idle == 255);
      end
      if (timeout) m_err = 1'b1;
      if (timeout || !bus.ld_req) m_mode = "RESUME";
    end else begin
      m_mode = "RUN";
    end
  endtask

  task automatic check_outputs();
    bit run, load;
    logic [5:0] pcv;
    logic [3:0] pidx;
    run  = (m_mode == "RUN");
    load = (m_mode == "LOAD");
    pcv  = bus.if_pc;
    pidx = pcv[5:2];
    chk("PCWrite",      64'(bus.PCWrite),      64'(run && !rst && !bus.hz_stall));
    chk("if_valid",     64'(bus.if_valid),     64'(run && !rst));
    chk("if_instr",     64'(bus.if_instr),     (run && !rst) ? 64'(ref_mem[pidx]) : 64'h0);
    chk("exc_misalign", 64'(bus.exc_misalign), 64'(run && (pcv[1:0] != 2'b00)));
    chk("pc_restart",   64'(bus.pc_restart),   64'(m_mode == "RESUME"));
    chk("ld_gnt",       64'(bus.ld_gnt),       64'(load));
    chk("ld_count",     64'(bus.ld_count),     64'(m_count));
    chk("ld_err",       64'(bus.ld_err),       64'(m_err));
    chk("mem_we",       64'(bus.mem_we),       64'(load && bus.ld_we && !rst));
    chk("mem_wdata",    64'(bus.mem_wdata),    64'(bus.ld_data));
    if (run)       chk("mem_addr_run",  64'(bus.mem_addr), 64'(pidx));
    else if (load) chk("mem_addr_load", 64'(bus.mem_addr), 64'(bus.ld_addr));
  endtask

  // One clock cycle: check settled outputs, let the memory and model see the edge.
  task automatic tick();
    logic       we;
    logic [3:0] wa;
    logic [31:0] wd;
    #1;
    check_outputs();
    we = bus.mem_we;
    wa = bus.mem_addr;
    wd = bus.mem_wdata;
    @(posedge clk);
    if (we) tb_mem[wa] = wd;
    model_update();
    @(negedge clk);
  endtask

  logic [31:0] dat [3];

  initial begin
    rst          = 1'b1;
    bus.if_pc    = '0;
    bus.hz_stall = 1'b0;
    bus.ld_req   = 1'b0;
    bus.ld_we    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();                       // reset state, outputs masked by rst
    rst = 1'b0;

    // plain fetch
    bus.if_pc = 6'd0; tick();
    bus.if_pc = 6'd4; tick();
    bus.if_pc = 6'd8; tick();
    // stall holds PC but the fetch stays valid
    bus.hz_stall = 1'b1; tick(); tick();
    bus.hz_stall = 1'b0;
    // misaligned fetch
    bus.if_pc = 6'd6;
    #1 chk("misalign_pc6", 64'(bus.exc_misalign), 64'd1);
    chk("misalign_addr", 64'(bus.mem_addr), 64'd1);
    tick();
    repeat (10) begin
      bus.if_pc    = 6'($urandom);
      bus.hz_stall = 1'($urandom);
      tick();
    end
    bus.hz_stall = 1'b0;
    bus.if_pc    = 6'd0;

    // three-word burst, then fetch from 0 returns the first word
    for (int k = 0; k < 3; k++) dat[k] = $urandom;
    bus.ld_req = 1'b1; tick();    // RUN samples request
    #1 chk("gnt_not_yet", 64'(bus.ld_gnt), 64'd0);
    tick();                       // QUIESCE
    for (int k = 0; k < 3; k++) begin
      bus.ld_we   = 1'b1;
      bus.ld_addr = 4'(k);
      bus.ld_data = dat[k];
      tick();
    end
    bus.ld_we  = 1'b0;
    bus.ld_req = 1'b0;
    #1 chk("count_3", 64'(bus.ld_count), 64'd3);
    tick();                       // LOAD sees request drop
    #1 chk("restart_pulse", 64'(bus.pc_restart), 64'd1);
    tick();                       // RESUME
    #1 chk("fetch_word0", 64'(bus.if_instr), 64'(dat[0]));
    tick();
    tick();

    // 20 writes saturate the word count
    bus.ld_req = 1'b1; tick(); tick();
    for (int k = 0; k < 20; k++) begin
      bus.ld_we   = 1'b1;
      bus.ld_addr = 4'($urandom);
      bus.ld_data = $urandom;
      tick();
    end
    bus.ld_we  = 1'b0;
    bus.ld_req = 1'b0;
    #1 chk("count_sat", 64'(bus.ld_count), 64'd16);
    tick(); tick(); tick();

    // idle timeout with request held; request still high restarts a burst
    bus.ld_req = 1'b1; tick(); tick();
    repeat (255) tick();
    #1 chk("timeout_err", 64'(bus.ld_err), 64'd1);
    chk("timeout_resume", 64'(bus.pc_restart), 64'd1);
    tick();                       // RESUME
    #1 chk("rerun_valid", 64'(bus.if_valid), 64'd1);
    tick();                       // RUN for one cycle
    tick();                       // QUIESCE
    #1 chk("err_cleared", 64'(bus.ld_err), 64'd0);
    bus.ld_we = 1'b1; bus.ld_addr = 4'd5; bus.ld_data = $urandom; tick();
    bus.ld_addr = 4'd6; bus.ld_data = $urandom; tick();
    // reset in the middle of LOAD
    rst = 1'b1; tick();
    rst = 1'b0;
    bus.ld_we  = 1'b0;
    bus.ld_req = 1'b0;
    #1 chk("gnt_after_rst", 64'(bus.ld_gnt), 64'd0);
    tick();

    // request dropped while quiescing still passes through LOAD
    bus.ld_req = 1'b1; tick();
    bus.ld_req = 1'b0; tick(); tick(); tick(); tick();

    // random mixed traffic
    repeat (300) begin
      if ($urandom_range(0, 15) == 0) bus.ld_req = ~bus.ld_req;
      rst          = ($urandom_range(0, 63) == 0);
      bus.ld_we    = 1'($urandom);
      bus.ld_addr  = 4'($urandom);
      bus.ld_data  = $urandom;
      bus.if_pc    = 6'($urandom);
      bus.hz_stall = 1'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
